// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM state encodings and datapath select codes for the RV32I controller
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd11,
    LUI      = 4'd12
  } state_t;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
endpackage

// File: rtl/multicycle_maindec_if.sv
// multicycle_maindec_if: opcode/handshake inputs and control outputs of the main decoder
interface multicycle_maindec_if #(
  parameter int IMM_SRC_W = 3,
  parameter int STATE_W = 4
);
  logic [6:0] op;
  logic mem_ready;
  logic PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [IMM_SRC_W-1:0] ImmSrc;
  logic [STATE_W-1:0] state_dbg;
  modport master (
    output op, mem_ready,
    input PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, illegal,
    input ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, state_dbg
  );
  modport slave (
    input op, mem_ready,
    output PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, illegal,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, state_dbg
  );
endinterface

// File: rtl/multicycle_maindec_imm_src_dec.sv
// imm_src_dec: combinational opcode to immediate-format select
module imm_src_dec
  import riscv_ctrl_pkg::*;
#(
  parameter int IMM_SRC_W = 3,
  parameter int EN_LUI = 1
) (
  input  logic [6:0]           op,
  output logic [IMM_SRC_W-1:0] imm_src
);
  always_comb
    imm_src = (op == OP_SW)  ? IMM_SRC_W'(1) :
              (op == OP_BEQ) ? IMM_SRC_W'(2) :
              (op == OP_JAL) ? IMM_SRC_W'(3) :
              (EN_LUI != 0 && op == OP_LUI) ? IMM_SRC_W'(4) : '0;
endmodule

// File: rtl/multicycle_maindec.sv
// multicycle_maindec: main control FSM sequencing multicycle RV32I instructions
module multicycle_maindec
  import riscv_ctrl_pkg::*;
#(
  parameter int IMM_SRC_W = 3,
  parameter int EN_LUI = 1,
  parameter int STATE_W = 4
) (
  input logic clk,
  input logic reset_n,
  multicycle_maindec_if.slave bus
);
  state_t state, state_nx;
  imm_src_dec #(.IMM_SRC_W(IMM_SRC_W), .EN_LUI(EN_LUI)) u_imm (.op(bus.op), .imm_src(bus.ImmSrc));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    bus.PCUpdate = 1'b0;
    bus.Branch = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite = 1'b0;
    bus.AdrSrc = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA = SRCA_PC;
    bus.ALUSrcB = SRCB_RS2;
    bus.ALUOp = ALUOP_ADD;
    bus.illegal = state == ILLEGAL;
    bus.state_dbg = STATE_W'(state);
    case (state)
      FETCH: begin
        bus.ALUSrcB = SRCB_FOUR;
        bus.ResultSrc = RES_ALURES;
        bus.IRWrite = bus.mem_ready;
        bus.PCUpdate = bus.mem_ready;
        state_nx = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        state_nx = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                   (bus.op == OP_R)   ? EXECUTER :
                   (bus.op == OP_I)   ? EXECUTEI :
                   (bus.op == OP_BEQ) ? BEQ :
                   (bus.op == OP_JAL) ? JAL :
                   (EN_LUI != 0 && bus.op == OP_LUI) ? LUI : ILLEGAL;
      end
      MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        state_nx = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        state_nx = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite = 1'b1;
        state_nx = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        bus.MemWrite = 1'b1;
        state_nx = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUOp = ALUOP_FUNCT;
        state_nx = ALUWB;
      end
      EXECUTEI: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp = ALUOP_FUNCT;
        state_nx = ALUWB;
      end
      LUI: begin
        bus.ALUSrcA = SRCA_ZERO;
        bus.ALUSrcB = SRCB_IMM;
        state_nx = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        state_nx = FETCH;
      end
      BEQ: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUOp = ALUOP_SUB;
        bus.Branch = 1'b1;
        state_nx = FETCH;
      end
      JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        bus.PCUpdate = 1'b1;
        state_nx = ALUWB;
      end
      ILLEGAL: state_nx = ILLEGAL;
      default: state_nx = FETCH;
    endcase
  end
endmodule
